// File: rtl/fir_seq_ctrl.sv
// Sequential FIR controller: host pushes samples or loads coefficients, one MAC per cycle.
// Build option: define FIR_SATURATE_EN to saturate the result instead of wrapping it.
module fir_seq_ctrl #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_idx,
  input  logic [DATA_WIDTH-1:0]       cmd_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_WIDTH-1:0]       res_data,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [IDX_W-1:0] TAP_LAST = IDX_W'(NUM_REGS - 1);

  logic [1:0]                   state;
  logic                         ready_en;
  logic [IDX_W-1:0]             tap;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] hist [NUM_REGS];
  logic signed [DATA_WIDTH-1:0] coef [NUM_REGS];
  logic signed [PROD_W-1:0]     prod;
  logic [DATA_WIDTH-1:0]        res_conv;
  logic                         accept;
  logic                         idx_ok;

  // cmd_ready is held low until the first edge after reset is released.
  assign cmd_ready = ready_en & (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign idx_ok    = (32'(cmd_idx) < NUM_REGS);

  // Operands are widened first so the product keeps its sign and full width.
  assign prod = PROD_W'(hist[tap]) * PROD_W'(coef[tap]);

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // NOTE: every path assigns res_conv, so no latch is inferred.
  always_comb begin
    res_conv = acc[DATA_WIDTH-1:0];
    if (acc > SAT_MAX)
      res_conv = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc < SAT_MIN)
      res_conv = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  assign res_conv = acc[DATA_WIDTH-1:0];
`endif

  // NOTE: history and coefficients are flop arrays that must read as zero after
  // reset, so they are cleared in the async reset branch rather than left as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ready_en  <= 1'b0;
      tap       <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        hist[k] <= '0;
        coef[k] <= '0;
      end
    end else begin
      // NOTE: all state updates are non-blocking so the shift reads pre-edge values.
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_PUSH: begin
                for (int k = NUM_REGS - 1; k > 0; k--)
                  hist[k] <= hist[k-1];
                hist[0] <= cmd_data;
                acc     <= '0;
                tap     <= '0;
                state   <= S_MAC;
              end
              OP_LOAD: begin
                if (idx_ok)
                  coef[cmd_idx] <= cmd_data;
              end
              OP_CLEAR: begin
                for (int k = 0; k < NUM_REGS; k++)
                  hist[k] <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (tap == TAP_LAST)
            state <= S_RESP;
          else
            tap <= tap + 1'b1;
        end
        S_RESP: begin
          // First RESP cycle registers the result; it then holds until consumed.
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_data  <= res_conv;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized scoreboard bench for fir_seq_ctrl against a tap-sum reference model.
module tb_fir_seq_ctrl;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int AW = 2 * DW + IW;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [IW-1:0] cmd_idx = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          busy;

  fir_seq_ctrl #(.NUM_REGS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: filter taps as plain signed integers.
  logic signed [DW-1:0] m_coef [N];
  logic signed [DW-1:0] m_hist [N];

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_coef[i] = '0;
      m_hist[i] = '0;
    end
  endtask

  // y[n] = sum over taps of hist*coef, then reduced to DW bits.
  function automatic logic [DW-1:0] model_result();
    logic signed [AW-1:0] sum;
    logic signed [63:0]   p;
    logic signed [AW-1:0] maxv;
    logic signed [AW-1:0] minv;
    sum  = '0;
    maxv = AW'(64'sh7FFF_FFFF);
    minv = AW'(-64'sh8000_0000);
    for (int i = 0; i < N; i++) begin
      p   = 64'(m_hist[i]) * 64'(m_coef[i]);
      sum = sum + AW'(p);
    end
`ifdef FIR_SATURATE_EN
    if (sum > maxv) return 32'h7FFF_FFFF;
    if (sum < minv) return 32'h8000_0000;
`endif
    return sum[DW-1:0];
  endfunction

  task automatic send(input logic [1:0] op, input int idx, input logic [DW-1:0] data,
                      output int waits);
    int acc_edge;
    waits = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = IW'(idx);
    cmd_data  = data;
    while (!cmd_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", waits);
      cmd_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    case (op)
      2'd0: begin
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = data;
        sb.push_back('{model_result(), acc_edge});
      end
      2'd1: if (idx < N) m_coef[idx] = data;
      2'd2: for (int k = 0; k < N; k++) m_hist[k] = '0;
      default: ;
    endcase
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, busy=%0b, required 0", sb.size(), busy);
    end
  endtask

  // Monitor: latency checked when res_valid rises, data checked at handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_res_valid: res_valid=1 with no result pending, required 0");
        end else begin
          check("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
        end
      end
      if (res_valid && res_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", 64'(res_data), 64'(e.data));
      end
      prev_valid = res_valid;
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) #1 res_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [DW-1:0] d;
    model_reset();

    // Reset behaviour and cmd_ready release timing.
    #1 rst = 1'b1;
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_res_data",  64'(res_data), 0);
    check("rst_busy",      64'(busy), 0);
    repeat (3) @(posedge clk);
    #1 check("rst_hold_cmd_ready", 64'(cmd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_release_cmd_ready_low", 64'(cmd_ready), 0);
    @(posedge clk);
    #1 check("rst_release_cmd_ready_high", 64'(cmd_ready), 1);
    check("idle_busy", 64'(busy), 0);

    // All taps 1, push 1..8: running sums 1,3,6,...,36.
    for (int i = 0; i < N; i++) send(2'd1, i, 32'd1, w);
    for (int v = 1; v <= 8; v++) send(2'd0, 0, DW'(v), w);
    wait_drain();

    // Two-tap filter {2,-1}, with a history clear in between.
    send(2'd2, 0, '0, w);
    for (int i = 0; i < N; i++)
      send(2'd1, i, (i == 0) ? 32'd2 : (i == 1) ? 32'hFFFF_FFFF : 32'd0, w);
    send(2'd0, 0, 32'd5, w);
    send(2'd0, 0, 32'd7, w);
    send(2'd2, 0, '0, w);
    send(2'd0, 0, 32'd4, w);
    wait_drain();

    // Stall in RESP: result and status must hold while res_ready is low.
    res_ready = 1'b0;
    send(2'd0, 0, 32'd3, w);
    w = 0;
    while (!res_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("stall_res_valid_seen", 64'(res_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_res_valid", 64'(res_valid), 1);
      check("stall_res_data", 64'(res_data), (sb.size() != 0) ? 64'(sb[0].data) : 64'hDEAD);
      check("stall_cmd_ready", 64'(cmd_ready), 0);
      check("stall_busy", 64'(busy), 1);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_cmd_ready", 64'(cmd_ready), 1);
    check("release_busy", 64'(busy), 0);
    check("release_res_valid", 64'(res_valid), 0);

    // Reset during the third MAC cycle discards the pending result.
    send(2'd0, 0, 32'd9, w);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    void'(sb.pop_back());
    model_reset();
    #1;
    check("midmac_rst_res_valid", 64'(res_valid), 0);
    check("midmac_rst_res_data",  64'(res_data), 0);
    check("midmac_rst_busy",      64'(busy), 0);
    check("midmac_rst_cmd_ready", 64'(cmd_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midmac_no_result", 64'(res_valid), 0);

    // Coefficients were cleared by reset, so this result is zero.
    send(2'd0, 0, 32'd5, w);

    // A LOAD issued during MAC waits for IDLE and then takes effect.
    send(2'd1, 0, 32'd3, w);
    send(2'd0, 0, 32'd2, w);
    send(2'd1, 0, 32'd10, w);
    check("load_held_off", 64'(w > 0), 1);
    send(2'd0, 0, 32'd1, w);
    wait_drain();

    // Randomized mix of commands with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      d = (i < 30) ? DW'($urandom_range(0, 255)) - 32'd128 : DW'($urandom);
      if (r <= 5)      send(2'd0, 0, d, w);
      else if (r <= 7) send(2'd1, $urandom_range(0, N - 1), d, w);
      else if (r == 8) send(2'd2, 0, '0, w);
      else             send(2'd3, $urandom_range(0, N - 1), d, w);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 res_ready = 1'b1;
    wait_drain();

    // Overflow boundary: wraps to 1, or clamps to max when saturating.
    send(2'd2, 0, '0, w);
    for (int i = 0; i < N; i++) send(2'd1, i, (i == 0) ? 32'h7FFF_FFFF : 32'd0, w);
    send(2'd0, 0, 32'h7FFF_FFFF, w);
    send(2'd1, 1, 32'h7FFF_FFFF, w);
    send(2'd0, 0, 32'h7FFF_FFFF, w);
    send(2'd1, 0, 32'h8000_0000, w);
    send(2'd1, 1, 32'h8000_0000, w);
    send(2'd0, 0, 32'h7FFF_FFFF, w);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of filter taps (history depth), minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample/coefficient/result width, signed two's complement.
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1, host command present.
REQ-006 SHALL have port cmd_ready, output, 1, block accepts command this cycle.
REQ-007 SHALL have port cmd_op, input, 2, 0=PUSH_SAMPLE, 1=LOAD_COEF, 2=CLEAR_HIST, 3=reserved (accepted, no effect).
REQ-008 SHALL have port cmd_idx, input, $clog2(NUM_REGS), coefficient index for LOAD_COEF.
REQ-009 SHALL have port cmd_data, input, DATA_WIDTH, sample or coefficient value.
REQ-010 SHALL have port res_valid, output, 1, filter result available.
REQ-011 SHALL have port res_ready, input, 1, host consumes result.
REQ-012 SHALL have port res_data, output, DATA_WIDTH, filter output y[n].
REQ-013 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, MAC, RESP; cmd_ready = 1 only in IDLE.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid & cmd_ready are both 1.
REQ-016 LOAD_COEF SHALL write cmd_data to coef[cmd_idx] on accept; cmd_idx >= NUM_REGS SHALL be ignored; FSM stays IDLE.
REQ-017 CLEAR_HIST SHALL zero all history entries on accept; coefficients unchanged; FSM stays IDLE.
REQ-018 PUSH_SAMPLE SHALL on accept shift history (hist[k] <= hist[k-1], hist[0] <= cmd_data, oldest dropped), clear accumulator and tap counter, go to MAC.
REQ-019 MAC SHALL add one product hist[t]*coef[t] per cycle for t = 0..NUM_REGS-1, then go to RESP; exactly NUM_REGS cycles in MAC.
REQ-020 Products SHALL be 2*DATA_WIDTH signed; accumulator 2*DATA_WIDTH+$clog2(NUM_REGS) bits signed, no internal overflow.
REQ-021 res_data SHALL equal accumulator bits [DATA_WIDTH-1:0] (see REQ-029 for saturation build).
REQ-022 In RESP res_valid SHALL be 1 and res_data stable until res_valid & res_ready; then FSM returns to IDLE next cycle.
REQ-023 Latency: res_valid SHALL rise exactly NUM_REGS+1 edges after the PUSH_SAMPLE accept edge when no stall.
REQ-024 res_ready high outside RESP SHALL have no effect; cmd_valid outside IDLE SHALL be held off (not lost) by cmd_ready=0.
REQ-025 Coefficient and history registers SHALL not change during MAC or RESP.

Reset
REQ-026 rst high SHALL asynchronously force FSM to IDLE, res_valid=0, res_data=0, busy=0, cmd_ready=0 while rst held, accumulator and tap counter 0, all history 0, all coefficients 0.
REQ-027 cmd_ready SHALL assert on the first rising edge after rst deasserts; reset mid-MAC or mid-RESP SHALL discard the pending result with no res_valid pulse.

Configuration
REQ-028 Macro FIR_SATURATE_EN SHALL select result conversion.
REQ-029 With FIR_SATURATE_EN defined: accumulator above 2^(DATA_WIDTH-1)-1 SHALL give that max, below -2^(DATA_WIDTH-1) that min, else low bits; without it: plain truncation (wrap) per REQ-021.

Verification
REQ-030 Reset then LOAD_COEF all 8 taps = 1, PUSH 1..8 -> results 1,3,6,10,15,21,28,36, each res_valid exactly 9 edges after accept.
REQ-031 Coefs = {2,-1,0,0,0,0,0,0}, PUSH 5 then PUSH 7 -> results 10 then 9; CLEAR_HIST then PUSH 4 -> 8.
REQ-032 Hold res_ready=0 for 20 cycles in RESP -> res_valid and res_data constant, cmd_ready 0, busy 1; release -> IDLE next cycle.
REQ-033 coef[0]=0x7FFFFFFF, PUSH 0x7FFFFFFF -> 0x00000001 without FIR_SATURATE_EN, 0x7FFFFFFF with it.
REQ-034 Assert rst at 3rd MAC cycle -> outputs at reset values immediately, no res_valid afterwards; LOAD_COEF idx 9 (NUM_REGS=8 build with 4-bit idx via NUM_REGS=9 check skipped) replaced by: LOAD_COEF during MAC held off until IDLE, then applied.
